// File: rtl/up_wishbone_pipelined.sv
// up_wishbone_pipelined: pipelined Wishbone slave bridged to a simple uP
// request/ack bus. Accepted requests are queued and issued one at a time.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   s_wb_cyc/stb/we/addr/data_i/sel  Wishbone request inputs
//   s_wb_stall                    request not accepted this cycle
//   s_wb_ack / s_wb_err           normal / timeout completion pulse
//   s_wb_data_o                   read data (valid only with ack)
//   up_rreq/rack/raddr/rdata      uP read port
//   up_wreq/wack/waddr/wdata/wsel uP write port
module up_wishbone_pipelined #(
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned BUS_WIDTH     = 4,
  parameter int unsigned QUEUE_DEPTH   = 4,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_wb_cyc,
  input  logic                       s_wb_stb,
  input  logic                       s_wb_we,
  input  logic [ADDRESS_WIDTH-1:0]   s_wb_addr,
  input  logic [BUS_WIDTH*8-1:0]     s_wb_data_i,
  input  logic [BUS_WIDTH-1:0]       s_wb_sel,
  output logic                       s_wb_stall,
  output logic                       s_wb_ack,
  output logic                       s_wb_err,
  output logic [BUS_WIDTH*8-1:0]     s_wb_data_o,
  output logic                       up_rreq,
  input  logic                       up_rack,
  output logic [ADDRESS_WIDTH-1:0]   up_raddr,
  input  logic [BUS_WIDTH*8-1:0]     up_rdata,
  output logic                       up_wreq,
  input  logic                       up_wack,
  output logic [ADDRESS_WIDTH-1:0]   up_waddr,
  output logic [BUS_WIDTH*8-1:0]     up_wdata,
  output logic [BUS_WIDTH-1:0]       up_wsel
);

  localparam int unsigned DW = BUS_WIDTH * 8;
  localparam int unsigned EW = 1 + ADDRESS_WIDTH + DW + BUS_WIDTH;
  localparam int unsigned PW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = 16;
  localparam int unsigned HW = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RESP} state_e;

  state_e                 state_q, state_d;
  logic [EW-1:0]          mem_q [QUEUE_DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;
  logic                   we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DW-1:0]          data_q, data_d;
  logic [BUS_WIDTH-1:0]   sel_q, sel_d;
  logic                   ack_q, ack_d, err_q, err_d;
  logic [DW-1:0]          rdata_q, rdata_d;

  logic                   full, push, pop, ack_hit;
  logic                   head_we;
  logic [ADDRESS_WIDTH-1:0] head_addr;
  logic [DW-1:0]          head_data;
  logic [BUS_WIDTH-1:0]   head_sel;
  logic [DW-1:0]          rdata_masked;

  // Stall depends only on registered state
  assign full       = (count_q == CW'(QUEUE_DEPTH));
  assign s_wb_stall = full | (hold_q != '0);
  assign push       = s_wb_cyc & s_wb_stb & ~s_wb_stall;

  assign {head_we, head_addr, head_data, head_sel} = mem_q[rd_ptr_q];

  // Only the ack of the port currently requesting counts
  assign ack_hit = we_q ? up_wack : up_rack;

  // Read data with unselected byte lanes zeroed
  always_comb begin
    rdata_masked = '0;
    for (int b = 0; b < int'(BUS_WIDTH); b++) begin
      if (sel_q[b]) rdata_masked[b*8 +: 8] = up_rdata[b*8 +: 8];
    end
  end

  // Next-state: issue FSM, queue pointers, timeout and reset-hold counters
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    hold_d   = hold_q;
    tcnt_d   = tcnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    data_d   = data_q;
    sel_d    = sel_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rdata_d  = '0;
    pop      = 1'b0;

    if (hold_q != '0) hold_d = hold_q - HW'(1);

    case (state_q)
      ST_IDLE: begin
        if (s_wb_cyc && (count_q != '0)) begin
          pop     = 1'b1;
          we_d    = head_we;
          addr_d  = head_addr;
          data_d  = head_data;
          sel_d   = head_sel;
          tcnt_d  = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Ack is checked before timeout so a coincident ack wins
        if (!s_wb_cyc) begin
          state_d = ST_IDLE;
        end else if (ack_hit) begin
          state_d = ST_RESP;
          ack_d   = 1'b1;
          if (!we_q) rdata_d = rdata_masked;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Dropping cyc flushes everything queued
    if (!s_wb_cyc) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= HW'(8);
      tcnt_q   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      sel_q    <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
      tcnt_q   <= tcnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      sel_q    <= sel_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // Queue storage; contents are don't-care until counted in
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {s_wb_we, s_wb_addr, s_wb_data_i, s_wb_sel};
  end

  // uP-side outputs: only the active port carries the latched request
  assign up_rreq     = (state_q == ST_ISSUE) & ~we_q;
  assign up_wreq     = (state_q == ST_ISSUE) &  we_q;
  assign up_raddr    = up_rreq ? addr_q : '0;
  assign up_waddr    = up_wreq ? addr_q : '0;
  assign up_wdata    = up_wreq ? data_q : '0;
  assign up_wsel     = up_wreq ? sel_q  : '0;

  assign s_wb_ack    = ack_q;
  assign s_wb_err    = err_q;
  assign s_wb_data_o = rdata_q;

endmodule

// File: tb/tb_up_wishbone_pipelined.sv
// Directed testbench for up_wishbone_pipelined (TIMEOUT=10, depth 4, 32-bit bus).
module tb_up_wishbone_pipelined;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_wb_cyc = 1'b0, s_wb_stb = 1'b0, s_wb_we = 1'b0;
  logic [15:0] s_wb_addr = '0;
  logic [31:0] s_wb_data_i = '0;
  logic [3:0]  s_wb_sel = '0;
  logic        s_wb_stall, s_wb_ack, s_wb_err;
  logic [31:0] s_wb_data_o;
  logic        up_rreq, up_wreq;
  logic        up_rack = 1'b0, up_wack = 1'b0;
  logic [15:0] up_raddr, up_waddr;
  logic [31:0] up_rdata = '0;
  logic [31:0] up_wdata;
  logic [3:0]  up_wsel;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  up_wishbone_pipelined #(
    .ADDRESS_WIDTH(16), .BUS_WIDTH(4), .QUEUE_DEPTH(4), .TIMEOUT(10)
  ) dut (
    .clk(clk), .rst(rst),
    .s_wb_cyc(s_wb_cyc), .s_wb_stb(s_wb_stb), .s_wb_we(s_wb_we),
    .s_wb_addr(s_wb_addr), .s_wb_data_i(s_wb_data_i), .s_wb_sel(s_wb_sel),
    .s_wb_stall(s_wb_stall), .s_wb_ack(s_wb_ack), .s_wb_err(s_wb_err),
    .s_wb_data_o(s_wb_data_o),
    .up_rreq(up_rreq), .up_rack(up_rack), .up_raddr(up_raddr), .up_rdata(up_rdata),
    .up_wreq(up_wreq), .up_wack(up_wack), .up_waddr(up_waddr),
    .up_wdata(up_wdata), .up_wsel(up_wsel)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bit bad;
    rst = 1'b1; s_wb_cyc = 1'b0; s_wb_stb = 1'b0;
    step(); step();
    checks++; if (s_wb_stall !== 1'b1) begin failures++; $display("FAIL reset_stall got %b exp 1", s_wb_stall); end
    checks++; if (s_wb_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got %b exp 0", s_wb_ack); end
    checks++; if (s_wb_err !== 1'b0) begin failures++; $display("FAIL reset_err got %b exp 0", s_wb_err); end
    checks++; if ({up_rreq, up_wreq} !== 2'b00) begin failures++; $display("FAIL reset_req got %b exp 00", {up_rreq, up_wreq}); end
    checks++; if (s_wb_data_o !== 32'h0) begin failures++; $display("FAIL reset_data got %h exp 0", s_wb_data_o); end
    checks++; if ({up_raddr, up_waddr, up_wdata, up_wsel} !== 68'h0) begin failures++; $display("FAIL reset_upbus got nonzero exp 0"); end
    // Release reset while offering a request: none may be taken during hold
    rst = 1'b0; s_wb_cyc = 1'b1; s_wb_stb = 1'b1; s_wb_addr = 16'h0EEE; s_wb_sel = 4'hF;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (s_wb_stall !== 1'b1) bad = 1'b1;
      step();
    end
    checks++; if (bad) begin failures++; $display("FAIL reset_hold_stall got 0 during hold exp 1"); end
    s_wb_stb = 1'b0;
    checks++; if (s_wb_stall !== 1'b0) begin failures++; $display("FAIL reset_hold_end got %b exp 0", s_wb_stall); end
    step(); step();
    checks++; if (up_rreq !== 1'b0) begin failures++; $display("FAIL reset_hold_noaccept got rreq %b exp 0", up_rreq); end
  endtask

  task automatic test_single_read();
    s_wb_cyc = 1'b1; s_wb_stb = 1'b1; s_wb_we = 1'b0; s_wb_addr = 16'h0010; s_wb_sel = 4'hF;
    step();
    s_wb_stb = 1'b0;
    checks++; if (up_rreq !== 1'b0) begin failures++; $display("FAIL read_req_early got %b exp 0", up_rreq); end
    step();
    checks++; if (up_rreq !== 1'b1) begin failures++; $display("FAIL read_req got %b exp 1", up_rreq); end
    checks++; if (up_raddr !== 16'h0010) begin failures++; $display("FAIL read_raddr got %h exp 0010", up_raddr); end
    checks++; if ({up_wreq, up_waddr} !== 17'h0) begin failures++; $display("FAIL read_wport got %h exp 0", {up_wreq, up_waddr}); end
    step();
    up_rack = 1'b1; up_rdata = 32'hDEADBEEF;
    step();
    up_rack = 1'b0;
    checks++; if ({s_wb_ack, s_wb_err} !== 2'b10) begin failures++; $display("FAIL read_ack got ack/err %b exp 10", {s_wb_ack, s_wb_err}); end
    checks++; if (s_wb_data_o !== 32'hDEADBEEF) begin failures++; $display("FAIL read_data got %h exp deadbeef", s_wb_data_o); end
    checks++; if (up_rreq !== 1'b0) begin failures++; $display("FAIL read_req_drop got %b exp 0", up_rreq); end
    step();
    checks++; if ({s_wb_ack, s_wb_data_o} !== 33'h0) begin failures++; $display("FAIL read_after got %h exp 0", {s_wb_ack, s_wb_data_o}); end
  endtask

  task automatic test_write();
    s_wb_stb = 1'b1; s_wb_we = 1'b1; s_wb_addr = 16'h0024; s_wb_data_i = 32'h12345678; s_wb_sel = 4'h3;
    step();
    s_wb_stb = 1'b0; s_wb_we = 1'b0;
    step();
    checks++; if (up_wreq !== 1'b1) begin failures++; $display("FAIL write_req got %b exp 1", up_wreq); end
    checks++; if (up_waddr !== 16'h0024) begin failures++; $display("FAIL write_waddr got %h exp 0024", up_waddr); end
    checks++; if (up_wdata !== 32'h12345678) begin failures++; $display("FAIL write_wdata got %h exp 12345678", up_wdata); end
    checks++; if (up_wsel !== 4'h3) begin failures++; $display("FAIL write_wsel got %h exp 3", up_wsel); end
    checks++; if ({up_rreq, up_raddr} !== 17'h0) begin failures++; $display("FAIL write_rport got %h exp 0", {up_rreq, up_raddr}); end
    up_rack = 1'b1;   // wrong-port ack must be ignored
    step();
    up_rack = 1'b0;
    checks++; if ({s_wb_ack, up_wreq} !== 2'b01) begin failures++; $display("FAIL write_wrong_port got ack/wreq %b exp 01", {s_wb_ack, up_wreq}); end
    up_wack = 1'b1;
    step();
    up_wack = 1'b0;
    checks++; if ({s_wb_ack, s_wb_err} !== 2'b10) begin failures++; $display("FAIL write_ack got %b exp 10", {s_wb_ack, s_wb_err}); end
    checks++; if ({s_wb_data_o, up_wdata, up_wsel, up_wreq} !== 69'h0) begin failures++; $display("FAIL write_idle_bus got nonzero exp 0"); end
    step();
  endtask

  task automatic test_back_to_back();
    int sent = 0, acks = 0, w = 0;
    bit stall_seen = 1'b0, err_seen = 1'b0, accept;
    logic [31:0] exp;
    s_wb_cyc = 1'b1; s_wb_we = 1'b0; s_wb_sel = 4'hF;
    for (int c = 0; c < 120; c++) begin
      if (s_wb_ack) begin
        exp = {16'hCAFE, 16'h0100 + 16'(acks)};
        checks++; if (s_wb_data_o !== exp) begin failures++; $display("FAIL b2b_order ack %0d got %h exp %h", acks, s_wb_data_o, exp); end
        acks++;
      end
      if (s_wb_err) err_seen = 1'b1;
      if (s_wb_stall) stall_seen = 1'b1;
      // Slow uP: acks on the 4th cycle of each read
      if (up_rreq) begin
        if (w == 3) begin up_rack = 1'b1; up_rdata = {16'hCAFE, up_raddr}; w = 0; end
        else begin up_rack = 1'b0; w++; end
      end else begin
        up_rack = 1'b0; w = 0;
      end
      s_wb_stb  = (sent < 6);
      s_wb_addr = 16'h0100 + 16'(sent);
      accept = s_wb_stb && !s_wb_stall;
      step();
      if (accept) sent++;
    end
    s_wb_stb = 1'b0; up_rack = 1'b0;
    checks++; if (sent != 6) begin failures++; $display("FAIL b2b_sent got %0d exp 6", sent); end
    checks++; if (acks != 6) begin failures++; $display("FAIL b2b_acks got %0d exp 6", acks); end
    checks++; if (!stall_seen) begin failures++; $display("FAIL b2b_stall got 0 exp 1"); end
    checks++; if (err_seen) begin failures++; $display("FAIL b2b_err got 1 exp 0"); end
  endtask

  task automatic test_timeout();
    int n = 0;
    s_wb_cyc = 1'b1; s_wb_stb = 1'b1; s_wb_we = 1'b0; s_wb_addr = 16'h0200; s_wb_sel = 4'hF;
    step();
    s_wb_addr = 16'h0204; s_wb_sel = 4'h5;
    step();
    s_wb_stb = 1'b0;
    while (up_rreq && up_raddr == 16'h0200 && n < 30) begin n++; step(); end
    checks++; if (n != 10) begin failures++; $display("FAIL tmo_req_cycles got %0d exp 10", n); end
    checks++; if ({s_wb_err, s_wb_ack} !== 2'b10) begin failures++; $display("FAIL tmo_err got err/ack %b exp 10", {s_wb_err, s_wb_ack}); end
    step();
    checks++; if (s_wb_err !== 1'b0) begin failures++; $display("FAIL tmo_err_pulse got %b exp 0", s_wb_err); end
    n = 0;
    while (!up_rreq && n < 10) begin n++; step(); end
    checks++; if ({up_rreq, up_raddr} !== {1'b1, 16'h0204}) begin failures++; $display("FAIL tmo_next_issue got %h exp 10204", {up_rreq, up_raddr}); end
    up_rack = 1'b1; up_rdata = 32'h11223344;
    step();
    up_rack = 1'b0;
    checks++; if ({s_wb_ack, s_wb_err} !== 2'b10) begin failures++; $display("FAIL tmo_next_ack got %b exp 10", {s_wb_ack, s_wb_err}); end
    checks++; if (s_wb_data_o !== 32'h00220044) begin failures++; $display("FAIL tmo_sel_mask got %h exp 00220044", s_wb_data_o); end
    step();
  endtask

  task automatic test_ack_at_timeout();
    s_wb_cyc = 1'b1; s_wb_stb = 1'b1; s_wb_we = 1'b0; s_wb_addr = 16'h0300; s_wb_sel = 4'hF;
    step();
    s_wb_stb = 1'b0;
    step();
    for (int i = 1; i < 10; i++) step();
    checks++; if (up_rreq !== 1'b1) begin failures++; $display("FAIL tie_req_10th got %b exp 1", up_rreq); end
    up_rack = 1'b1; up_rdata = 32'h0BADF00D;
    step();
    up_rack = 1'b0;
    checks++; if ({s_wb_ack, s_wb_err} !== 2'b10) begin failures++; $display("FAIL tie_ack_wins got ack/err %b exp 10", {s_wb_ack, s_wb_err}); end
    checks++; if (s_wb_data_o !== 32'h0BADF00D) begin failures++; $display("FAIL tie_data got %h exp 0badf00d", s_wb_data_o); end
    step();
  endtask

  task automatic test_cyc_drop();
    bit bad = 1'b0;
    s_wb_cyc = 1'b1; s_wb_stb = 1'b1; s_wb_we = 1'b0; s_wb_sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      s_wb_addr = 16'h0400 + 16'(i);
      step();
    end
    s_wb_stb = 1'b0;
    checks++; if ({up_rreq, up_raddr} !== {1'b1, 16'h0400}) begin failures++; $display("FAIL drop_pre got %h exp 10400", {up_rreq, up_raddr}); end
    s_wb_cyc = 1'b0;
    step();
    checks++; if ({up_rreq, s_wb_ack, s_wb_err} !== 3'b000) begin failures++; $display("FAIL drop_abort got %b exp 000", {up_rreq, s_wb_ack, s_wb_err}); end
    s_wb_cyc = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (up_rreq || up_wreq || s_wb_ack || s_wb_err || s_wb_stall) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL drop_flushed got activity after flush exp none"); end
  endtask

  task automatic test_rst_mid();
    bit bad = 1'b0;
    int n = 0;
    s_wb_cyc = 1'b1; s_wb_stb = 1'b1; s_wb_we = 1'b0; s_wb_addr = 16'h0500; s_wb_sel = 4'hF;
    step();
    s_wb_stb = 1'b0;
    step(); step();
    checks++; if (up_rreq !== 1'b1) begin failures++; $display("FAIL rstmid_pre got %b exp 1", up_rreq); end
    rst = 1'b1;
    step();
    checks++; if ({up_rreq, up_raddr, s_wb_ack, s_wb_err, s_wb_stall} !== {1'b0, 16'h0, 3'b001}) begin failures++; $display("FAIL rstmid_outputs got %h exp 1", {up_rreq, up_raddr, s_wb_ack, s_wb_err, s_wb_stall}); end
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (s_wb_stall !== 1'b1 || s_wb_ack || s_wb_err || up_rreq) bad = 1'b1;
      step();
    end
    checks++; if (bad) begin failures++; $display("FAIL rstmid_hold got bad hold cycle exp stall only"); end
    checks++; if (s_wb_stall !== 1'b0) begin failures++; $display("FAIL rstmid_release got %b exp 0", s_wb_stall); end
    s_wb_stb = 1'b1; s_wb_addr = 16'h0510;
    step();
    s_wb_stb = 1'b0;
    while (!up_rreq && n < 10) begin n++; step(); end
    checks++; if ({up_rreq, up_raddr} !== {1'b1, 16'h0510}) begin failures++; $display("FAIL rstmid_read_req got %h exp 10510", {up_rreq, up_raddr}); end
    up_rack = 1'b1; up_rdata = 32'hA1B2C3D4;
    step();
    up_rack = 1'b0;
    checks++; if ({s_wb_ack, s_wb_data_o} !== {1'b1, 32'hA1B2C3D4}) begin failures++; $display("FAIL rstmid_read_ack got %h exp 1a1b2c3d4", {s_wb_ack, s_wb_data_o}); end
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_back_to_back();
    test_timeout();
    test_ack_at_timeout();
    test_cyc_drop();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule
